// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide sequencer: FSM state encodings,
// handshake levels and the default iteration counter width.
// No ports; imported by div_ctrl and div_ctrl_step.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Default iteration counter width; 2**DivCntBus must exceed the operand width.
  localparam int DivCntBus = 6;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring divide iteration (div_step): trial-subtract the divisor
// from the upper part of the working register, then shift in one quotient bit.
// Ports: work (2*WIDTH+1 working register), divisor (magnitude), work_nxt.
module div_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] work,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] work_nxt
);

  logic             borrow;
  logic [WIDTH-1:0] diff;

  // The partial remainder is always below 2*divisor, so when the trial is
  // non-negative the true difference fits in WIDTH bits.
  assign borrow = (work[2*WIDTH:WIDTH] < {1'b0, divisor});
  assign diff   = work[2*WIDTH-1:WIDTH] - divisor;

  always_comb begin
    if (borrow) begin
      work_nxt = {work[2*WIDTH-1:0], 1'b0};
    end else begin
      work_nxt = {diff, work[WIDTH-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: restoring divide, one quotient bit per cycle,
// sign fix-up at the end, result presented as {remainder, quotient}.
// Ports: clk, rst (async active-low), signed_div_i, opdata1_i (dividend),
//   opdata2_i (divisor), start_i, annul_i, result_o, ready_o, stallreq_o.
// Optional: define DIV_EARLY_EXIT_EN to finish at once when |dividend| < |divisor|.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = DivCntBus
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  div_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2*WIDTH:0]   work, work_nxt, step_out;
  logic [WIDTH-1:0]   dvs_mag, dvs_mag_nxt;
  logic               sgn, sgn_nxt, neg1, neg1_nxt, neg2, neg2_nxt;
  logic [2*WIDTH-1:0] result, result_nxt;
  logic               ready, ready_nxt;

  logic [WIDTH-1:0]   op1_mag, op2_mag, quo, rem, quo_fix, rem_fix;

  // Magnitudes only differ from the raw operands for negative signed inputs.
  assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign quo     = work[WIDTH-1:0];
  assign rem     = work[2*WIDTH:WIDTH+1];
  assign quo_fix = (sgn && (neg1 ^ neg2)) ? -quo : quo;
  assign rem_fix = (sgn && neg1) ? -rem : rem;

  div_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .work     (work),
    .divisor  (dvs_mag),
    .work_nxt (step_out)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    work_nxt    = work;
    dvs_mag_nxt = dvs_mag;
    sgn_nxt     = sgn;
    neg1_nxt    = neg1;
    neg2_nxt    = neg2;
    result_nxt  = result;
    ready_nxt   = ready;

    case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DivByZero;
`ifdef DIV_EARLY_EXIT_EN
          end else if (op1_mag < op2_mag) begin
            // Quotient is 0 and remainder is the dividend untouched; ready
            // follows one edge later from DivEnd, matching the by-zero path.
            state_nxt  = DivEnd;
            result_nxt = {opdata1_i, {WIDTH{1'b0}}};
`endif
          end else begin
            state_nxt   = DivOn;
            dvs_mag_nxt = op2_mag;
            sgn_nxt     = signed_div_i;
            neg1_nxt    = opdata1_i[WIDTH-1];
            neg2_nxt    = opdata2_i[WIDTH-1];
            work_nxt    = {{WIDTH{1'b0}}, op1_mag, 1'b0};
            cnt_nxt     = '0;
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_nxt  = DivFree;
          result_nxt = '0;
          ready_nxt  = DivResultNotReady;
        end else begin
          state_nxt  = DivEnd;
          result_nxt = '0;
          ready_nxt  = DivResultReady;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_nxt  = DivFree;
          result_nxt = '0;
          ready_nxt  = DivResultNotReady;
        end else if (cnt == CNT_W'(WIDTH)) begin
          state_nxt  = DivEnd;
          result_nxt = {rem_fix, quo_fix};
          ready_nxt  = DivResultReady;
        end else begin
          work_nxt = step_out;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end

      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_nxt  = DivFree;
          result_nxt = '0;
          ready_nxt  = DivResultNotReady;
        end else begin
          ready_nxt = DivResultReady;
        end
      end

      default: begin
        state_nxt  = DivFree;
        result_nxt = '0;
        ready_nxt  = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DivFree;
      cnt     <= '0;
      work    <= '0;
      dvs_mag <= '0;
      sgn     <= 1'b0;
      neg1    <= 1'b0;
      neg2    <= 1'b0;
      result  <= '0;
      ready   <= DivResultNotReady;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      work    <= work_nxt;
      dvs_mag <= dvs_mag_nxt;
      sgn     <= sgn_nxt;
      neg1    <= neg1_nxt;
      neg2    <= neg2_nxt;
      result  <= result_nxt;
      ready   <= ready_nxt;
    end
  end

  assign result_o   = result;
  assign ready_o    = ready;
  assign stallreq_o = (state == DivByZero) || (state == DivOn);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus randomized divides
// compared against an arithmetic reference model.
// Honours DIV_EARLY_EXIT_EN when computing expected latency.
module tb_div_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   opdata1, opdata2;
  logic           start, annul;
  logic [2*W-1:0] result;
  logic           ready, stallreq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder takes the dividend's sign, which is the DIV convention.
  function automatic logic [63:0] model_res(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic longint mag(input logic sg, input logic [W-1:0] v);
    longint x;
    x = sg ? longint'($signed(v)) : longint'({32'd0, v});
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit model_short(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_EXIT_EN
    return (b != '0) && (mag(sg, a) < mag(sg, b));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_lat(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0 || model_short(sg, a, b)) return 1;
    return W + 1;
  endfunction

  // Start is already asserted; the next posedge is edge 0.
  task automatic await_result(input string tag, input logic [63:0] exp_res,
                              input int exp_lat, input bit exp_busy);
    int lat = -1;
    int bad_stall = 0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom);
      end
      if (ready) lat = k;
      else if (stallreq !== exp_busy) bad_stall++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_stall_busy"}, 64'(bad_stall), 64'd0);
    chk({tag, "_stall_done"}, 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_hold"}, {ready, result[62:0]}, {1'b1, exp_res[62:0]});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop"}, {ready, stallreq, result[61:0]}, 64'd0);
  endtask

  task automatic run_div(input string tag, input logic sg, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] exp_res);
    @(negedge clk);
    signed_div = sg;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    await_result(tag, exp_res, model_lat(sg, a, b), !model_short(sg, a, b));
  endtask

  initial begin
    bit seen;
    int lat;
    logic [W-1:0] ra, rb;
    logic rs;

    rst = 1'b0; start = 1'b0; annul = 1'b0;
    signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    #12;
    chk("reset_out", {ready, stallreq, result[61:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with hand-computed results
    run_div("u100_7",   1'b0, 32'd100,       32'd7,         {32'h00000002, 32'h0000000E});
    run_div("sm100_7",  1'b1, 32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE, 32'hFFFFFFF2});
    run_div("s100_m7",  1'b1, 32'd100,       32'hFFFFFFF9,  {32'h00000002, 32'hFFFFFFF2});
    run_div("u_by0",    1'b0, 32'd1234,      32'd0,         64'd0);
    run_div("s_by0",    1'b1, 32'hFFFF0000,  32'd0,         64'd0);
    run_div("s_minm1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h00000000, 32'h80000000});
    run_div("u5_9",     1'b0, 32'd5,         32'd9,         {32'h00000005, 32'h00000000});
    run_div("s_m5_9",   1'b1, 32'hFFFFFFFB,  32'd9,         {32'hFFFFFFFB, 32'h00000000});
    run_div("u_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         {32'h00000000, 32'hFFFFFFFF});

    // Annul mid-divide with start held: annul wins, then a new op starts
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
    @(posedge clk); #1;
    if (ready) seen = 1'b1;
    chk("annul_free", {ready, stallreq, result[61:0]}, 64'd0);
    chk("annul_noready", 64'(seen), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    await_result("after_annul", {32'd0, 32'd10}, W + 1, 1'b1);

    // Annul in END while start is still held
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd20; opdata2 = 32'd3; start = 1'b1;
    lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (ready) lat = k;
    end
    chk("end_annul_lat", 64'(lat), 64'(model_lat(1'b0, 32'd20, 32'd3)));
    chk("end_annul_res", result, {32'd2, 32'd6});
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    chk("end_annul", {ready, stallreq, result[61:0]}, 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("end_annul_idle", {ready, stallreq}, 64'd0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {ready, stallreq, result[61:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    run_div("post_rst", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

    // Randomized divides against the reference model
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 15);
        1:       rb = $urandom;
        2:       rb = $urandom_range(1, 1000);
        default: rb = ra >> $urandom_range(0, 8);
      endcase
      if (($urandom & 7) == 0) ra = $urandom_range(0, 20);
      run_div($sformatf("rnd%0d", i), rs, ra, rb, model_res(rs, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
